// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and helpers for the memory access controller: access sizes,
// FSM states and the alignment rule applied at request accept.
package mem_ctrl_pkg;

    localparam int WORD_BITS = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        WR_ISSUE = 3'd3,
        RESP     = 3'd4
    } state_t;

    function automatic logic is_misaligned(input size_t size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Core request/response handshake plus memory pin bundle. The master side is
// the requester and memory environment; the slave side is the controller.
interface mem_access_ctrl_if #(
    parameter int AddressSize = 16,
    parameter int WordSize    = 32
);
    logic                   ReqValid;
    logic                   ReqReady;
    logic                   ReqWrite;
    logic [1:0]             ReqSize;
    logic                   ReqSigned;
    logic [31:0]            ReqAddr;
    logic [31:0]            ReqWData;
    logic                   RspValid;
    logic [31:0]            RspRData;
    logic                   RspError;
    logic                   MemWriteEn;
    logic                   MemReadEn;
    logic [AddressSize-1:0] MemAddress;
    logic [WordSize-1:0]    MemWriteData;
    logic [WordSize-1:0]    MemReadData;

    modport master (
        output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, MemReadData,
        input  ReqReady, RspValid, RspRData, RspError,
        input  MemWriteEn, MemReadEn, MemAddress, MemWriteData
    );

    modport slave (
        input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, MemReadData,
        output ReqReady, RspValid, RspRData, RspError,
        output MemWriteEn, MemReadEn, MemAddress, MemWriteData
    );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian byte/half lane handling: extracts a load value from a read word
// and merges sub-word store data into a read word.
module mem_lane_align
    import mem_ctrl_pkg::*;
(
    input  logic [WORD_BITS-1:0] word,
    input  logic [1:0]           offset,
    input  size_t                size,
    input  logic                 is_signed,
    input  logic [WORD_BITS-1:0] store_data,
    output logic [WORD_BITS-1:0] load_data,
    output logic [WORD_BITS-1:0] merged_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        byte_lane   = word[{offset, 3'b000} +: 8];
        half_lane   = word[{offset[1], 4'b0000} +: 16];
        load_data   = word;
        merged_word = store_data;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{is_signed & byte_lane[7]}}, byte_lane};
                merged_word = word;
                merged_word[{offset, 3'b000} +: 8] = store_data[7:0];
            end
            SZ_HALF: begin
                load_data = {{16{is_signed & half_lane[15]}}, half_lane};
                merged_word = word;
                merged_word[{offset[1], 4'b0000} +: 16] = store_data[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator-side controller for a single-port synchronous word memory with
// one-cycle read latency; sub-word stores are done as read-modify-write.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int AddressSize = 16,
    parameter int WordSize    = 32
) (
    input  logic             Clock,
    input  logic             nReset,
    mem_access_ctrl_if.slave bus
);

    state_t                 state_q, state_d;
    size_t                  size_q, size_d;
    logic [1:0]             off_q, off_d;
    logic                   signed_q, signed_d;
    logic                   write_q, write_d;
    logic [31:0]            store_q, store_d;
    logic [AddressSize-1:0] addr_q, addr_d;

    logic                   mem_we_q, mem_we_d;
    logic                   mem_re_q, mem_re_d;
    logic [AddressSize-1:0] mem_addr_q, mem_addr_d;
    logic [WordSize-1:0]    mem_wdata_q, mem_wdata_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_error_q, rsp_error_d;
    logic [31:0]            rsp_rdata_q, rsp_rdata_d;

    logic                   accept;
    logic                   req_err;
    logic [31:0]            load_data;
    logic [31:0]            merged_word;

    mem_lane_align u_align (
        .word        (bus.MemReadData),
        .offset      (off_q),
        .size        (size_q),
        .is_signed   (signed_q),
        .store_data  (store_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    assign accept  = bus.ReqValid && (state_q == IDLE);
    assign req_err = (bus.ReqSize == SZ_BAD)
                  || is_misaligned(size_t'(bus.ReqSize), bus.ReqAddr[1:0])
                  || ((bus.ReqAddr >> (AddressSize + 2)) != 32'd0);

    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        off_d       = off_q;
        signed_d    = signed_q;
        write_d     = write_q;
        store_d     = store_q;
        addr_d      = addr_q;
        mem_wdata_d = '0;
        rsp_error_d = 1'b0;
        rsp_rdata_d = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    size_d   = size_t'(bus.ReqSize);
                    off_d    = bus.ReqAddr[1:0];
                    signed_d = bus.ReqSigned;
                    write_d  = bus.ReqWrite;
                    store_d  = bus.ReqWData;
                    addr_d   = bus.ReqAddr[AddressSize+1:2];
                    if (req_err) begin
                        state_d     = RESP;
                        rsp_error_d = 1'b1;
                    end else if (bus.ReqWrite && (bus.ReqSize == SZ_WORD)) begin
                        state_d     = WR_ISSUE;
                        mem_wdata_d = bus.ReqWData;
                    end else begin
                        state_d = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT: begin
                // The read word is only valid at the end of this cycle.
                if (write_q) begin
                    state_d     = WR_ISSUE;
                    mem_wdata_d = merged_word;
                end else begin
                    state_d     = RESP;
                    rsp_rdata_d = load_data;
                end
            end
            WR_ISSUE: state_d = RESP;
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        mem_re_d    = (state_d == RD_ISSUE);
        mem_we_d    = (state_d == WR_ISSUE);
        mem_addr_d  = (mem_re_d || mem_we_d) ? addr_d : '0;
        rsp_valid_d = (state_d == RESP);
    end

    // NOTE: non-blocking assignments only in sequential logic; every register,
    // outputs included, is cleared by the asynchronous reset.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q     <= IDLE;
            size_q      <= SZ_BYTE;
            off_q       <= '0;
            signed_q    <= 1'b0;
            write_q     <= 1'b0;
            store_q     <= '0;
            addr_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            off_q       <= off_d;
            signed_q    <= signed_d;
            write_q     <= write_d;
            store_q     <= store_d;
            addr_q      <= addr_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.ReqReady     = (state_q == IDLE);
    assign bus.RspValid     = rsp_valid_q;
    assign bus.RspError     = rsp_error_q;
    assign bus.RspRData     = rsp_rdata_q;
    assign bus.MemWriteEn   = mem_we_q;
    assign bus.MemReadEn    = mem_re_q;
    assign bus.MemAddress   = mem_addr_q;
    assign bus.MemWriteData = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a one-cycle-latency word memory model
// that drives its read data 20 time units after the clock edge.
module tb_mem_access_ctrl;

    logic Clock = 1'b0;
    logic nReset = 1'b0;

    mem_access_ctrl_if #(.AddressSize(16), .WordSize(32)) bus ();

    mem_access_ctrl #(.AddressSize(16), .WordSize(32)) dut (
        .Clock  (Clock),
        .nReset (nReset),
        .bus    (bus)
    );

    always #25 Clock = ~Clock;

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory model: commands sampled mid-cycle, effects applied 20 units after the edge.
    logic [31:0] mem [0:255];
    logic        mdl_re = 1'b0;
    logic        mdl_we = 1'b0;
    logic [15:0] mdl_addr = '0;
    logic [31:0] mdl_wd = '0;

    always @(negedge Clock) begin
        mdl_re   = bus.MemReadEn;
        mdl_we   = bus.MemWriteEn;
        mdl_addr = bus.MemAddress;
        mdl_wd   = bus.MemWriteData;
    end

    always @(posedge Clock) begin
        #20;
        if (mdl_we) mem[mdl_addr[7:0]] = mdl_wd;
        bus.MemReadData = mdl_re ? mem[mdl_addr[7:0]] : 32'd0;
    end

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } req_t;

    req_t seq [4];

    task automatic present(input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] addr, input logic [31:0] wd);
        bus.ReqWrite  = wr;
        bus.ReqSize   = sz;
        bus.ReqSigned = sg;
        bus.ReqAddr   = addr;
        bus.ReqWData  = wd;
    endtask

    task automatic do_req(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int exp_lat, input logic [31:0] exp_rd, input logic exp_err,
                          input int exp_re, input int exp_we, input logic [31:0] exp_wd);
        int          lat = 0;
        int          n_re = 0;
        int          n_we = 0;
        int          n_both = 0;
        int          first_re = 0;
        logic [31:0] rd = '0;
        logic        er = 1'b0;
        logic [31:0] seen_addr = '0;
        logic [31:0] seen_wd = '0;

        @(posedge Clock); #1;
        present(wr, sz, sg, addr, wd);
        bus.ReqValid = 1'b1;
        @(negedge Clock);
        check({tag, " ready"}, {31'd0, bus.ReqReady}, 32'd1);
        check({tag, " idle rsp"}, {31'd0, bus.RspValid}, 32'd0);
        @(posedge Clock); #1;
        bus.ReqValid = 1'b0;
        present(~wr, 2'b11, ~sg, 32'hFFFF_FFFC, 32'hA5A5_A5A5);
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge Clock);
            if (bus.MemReadEn) begin
                n_re++;
                if (first_re == 0) first_re = c;
                seen_addr = {16'd0, bus.MemAddress};
            end
            if (bus.MemWriteEn) begin
                n_we++;
                seen_addr = {16'd0, bus.MemAddress};
                seen_wd   = bus.MemWriteData;
            end
            if (bus.MemReadEn && bus.MemWriteEn) n_both++;
            if (bus.RspValid) begin
                lat = c;
                rd  = bus.RspRData;
                er  = bus.RspError;
            end
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " rdata"}, rd, exp_rd);
        check({tag, " error"}, {31'd0, er}, {31'd0, exp_err});
        check({tag, " read cycles"}, n_re, exp_re);
        check({tag, " write cycles"}, n_we, exp_we);
        check({tag, " rd+wr overlap"}, n_both, 0);
        if (n_re > 0) check({tag, " read at cycle"}, first_re, 1);
        if (n_re + n_we > 0) check({tag, " mem addr"}, seen_addr, {16'd0, addr[17:2]});
        if (n_we > 0) check({tag, " mem wdata"}, seen_wd, exp_wd);
    endtask

    initial begin
        int idx;
        int n_rsp;
        logic rdy;

        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        bus.MemReadData = 32'd0;
        bus.ReqValid = 1'b0;
        present(1'b0, 2'b00, 1'b0, 32'd0, 32'd0);

        seq[0] = '{1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_CAFE, 32'h0000_0000, 1'b0};
        seq[1] = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0,         32'hCAFE_0000, 1'b0};
        seq[2] = '{1'b0, 2'b11, 1'b0, 32'h20, 32'h0,         32'h0000_0000, 1'b1};
        seq[3] = '{1'b0, 2'b00, 1'b1, 32'h23, 32'h0,         32'hFFFF_FFCA, 1'b0};

        repeat (2) @(posedge Clock);
        #1;
        check("reset ReqReady", {31'd0, bus.ReqReady}, 32'd1);
        check("reset RspValid", {31'd0, bus.RspValid}, 32'd0);
        check("reset RspError", {31'd0, bus.RspError}, 32'd0);
        check("reset RspRData", bus.RspRData, 32'd0);
        check("reset MemWriteEn", {31'd0, bus.MemWriteEn}, 32'd0);
        check("reset MemReadEn", {31'd0, bus.MemReadEn}, 32'd0);
        check("reset MemAddress", {16'd0, bus.MemAddress}, 32'd0);
        check("reset MemWriteData", bus.MemWriteData, 32'd0);
        @(negedge Clock);
        nReset = 1'b1;

        //      tag             wr    sz     sg    addr          wdata         lat rdata          err  re we wdata
        do_req("st word",      1'b1, 2'b10, 1'b0, 32'h10,       32'hDEADBEEF, 2, 32'h0,         1'b0, 0, 1, 32'hDEADBEEF);
        do_req("ld word",      1'b0, 2'b10, 1'b0, 32'h10,       32'h0,        3, 32'hDEADBEEF,  1'b0, 1, 0, 32'h0);
        do_req("st byte 13",   1'b1, 2'b00, 1'b0, 32'h13,       32'h0000_0011, 4, 32'h0,        1'b0, 1, 1, 32'h11ADBEEF);
        do_req("ld word 2",    1'b0, 2'b10, 1'b1, 32'h10,       32'h0,        3, 32'h11ADBEEF,  1'b0, 1, 0, 32'h0);
        do_req("ld sbyte 10",  1'b0, 2'b00, 1'b1, 32'h10,       32'h0,        3, 32'hFFFFFFEF,  1'b0, 1, 0, 32'h0);
        do_req("ld ubyte 10",  1'b0, 2'b00, 1'b0, 32'h10,       32'h0,        3, 32'h000000EF,  1'b0, 1, 0, 32'h0);
        do_req("ld shalf 10",  1'b0, 2'b01, 1'b1, 32'h10,       32'h0,        3, 32'hFFFFBEEF,  1'b0, 1, 0, 32'h0);
        do_req("ld shalf 12",  1'b0, 2'b01, 1'b1, 32'h12,       32'h0,        3, 32'h000011AD,  1'b0, 1, 0, 32'h0);
        do_req("st byte 11",   1'b1, 2'b00, 1'b0, 32'h11,       32'hFFFF_FF80, 4, 32'h0,        1'b0, 1, 1, 32'h11AD80EF);
        do_req("ld sbyte 11",  1'b0, 2'b00, 1'b1, 32'h11,       32'h0,        3, 32'hFFFFFF80,  1'b0, 1, 0, 32'h0);
        do_req("err word 12",  1'b0, 2'b10, 1'b0, 32'h12,       32'h0,        1, 32'h0,         1'b1, 0, 0, 32'h0);
        do_req("err half 11",  1'b0, 2'b01, 1'b0, 32'h11,       32'h0,        1, 32'h0,         1'b1, 0, 0, 32'h0);
        do_req("err size 11",  1'b0, 2'b11, 1'b0, 32'h10,       32'h0,        1, 32'h0,         1'b1, 0, 0, 32'h0);
        do_req("err range",    1'b0, 2'b10, 1'b0, 32'h0004_0000, 32'h0,       1, 32'h0,         1'b1, 0, 0, 32'h0);
        do_req("err st half",  1'b1, 2'b01, 1'b0, 32'h11,       32'h1234,     1, 32'h0,         1'b1, 0, 0, 32'h0);

        // Reset asserted while a load sits in RD_WAIT.
        @(posedge Clock); #1;
        present(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        bus.ReqValid = 1'b1;
        @(posedge Clock); #1;
        bus.ReqValid = 1'b0;
        @(posedge Clock); #5;
        check("pre-reset ReqReady", {31'd0, bus.ReqReady}, 32'd0);
        nReset = 1'b0;
        #1;
        check("mid-reset ReqReady", {31'd0, bus.ReqReady}, 32'd1);
        check("mid-reset RspValid", {31'd0, bus.RspValid}, 32'd0);
        check("mid-reset MemReadEn", {31'd0, bus.MemReadEn}, 32'd0);
        check("mid-reset MemWriteEn", {31'd0, bus.MemWriteEn}, 32'd0);
        check("mid-reset MemAddress", {16'd0, bus.MemAddress}, 32'd0);
        check("mid-reset RspRData", bus.RspRData, 32'd0);
        @(negedge Clock);
        @(negedge Clock);
        nReset = 1'b1;
        n_rsp = 0;
        repeat (6) begin
            @(negedge Clock);
            if (bus.RspValid) n_rsp++;
        end
        check("post-reset no rsp", n_rsp, 0);
        do_req("ld after rst", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 3, 32'h11AD80EF, 1'b0, 1, 0, 32'h0);

        // Back-to-back requests with ReqValid held high.
        @(posedge Clock); #1;
        idx = 0;
        n_rsp = 0;
        present(seq[0].wr, seq[0].sz, seq[0].sg, seq[0].addr, seq[0].wd);
        bus.ReqValid = 1'b1;
        for (int cyc = 0; cyc < 60 && n_rsp < 4; cyc++) begin
            @(negedge Clock);
            rdy = bus.ReqReady;
            if (bus.RspValid) begin
                if (n_rsp < 4) begin
                    check($sformatf("stream rsp%0d rdata", n_rsp), bus.RspRData, seq[n_rsp].exp_rd);
                    check($sformatf("stream rsp%0d error", n_rsp), {31'd0, bus.RspError},
                          {31'd0, seq[n_rsp].exp_err});
                end
                n_rsp++;
            end
            @(posedge Clock); #1;
            if (rdy && bus.ReqValid) begin
                check($sformatf("stream accept%0d in order", idx), n_rsp, idx);
                idx++;
                if (idx < 4) present(seq[idx].wr, seq[idx].sz, seq[idx].sg, seq[idx].addr, seq[idx].wd);
                else bus.ReqValid = 1'b0;
            end
        end
        bus.ReqValid = 1'b0;
        check("stream accepts", idx, 4);
        check("stream responses", n_rsp, 4);
        repeat (4) begin
            @(negedge Clock);
            if (bus.RspValid) n_rsp++;
        end
        check("stream no extra rsp", n_rsp, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Initiator-side controller for the single-port synchronous word memory. It accepts byte, halfword and word load/store requests from the core over a valid/ready handshake and drives the memory's WriteEn/ReadEn/Address/WriteData pins. It handles the memory's one-cycle read latency and performs read-modify-write for sub-word stores. It returns one response per request, with error flagging.

Parameters:
AddressSize, 16, memory word-address width; byte-address space is AddressSize+2 bits
WordSize, 32, memory word width; only 32 supported (4 byte lanes)

Ports:
Clock  in  1  system clock
nReset  in  1  asynchronous active-low reset
ReqValid  in  1  request valid
ReqReady  out  1  controller can accept a request
ReqWrite  in  1  1=store, 0=load
ReqSize  in  2  00 byte, 01 half, 10 word, 11 illegal
ReqSigned  in  1  sign-extend load result
ReqAddr  in  32  byte address
ReqWData  in  32  store data, right-justified
RspValid  out  1  one-cycle response pulse
RspRData  out  32  load result; 0 for stores and errors
RspError  out  1  misaligned, illegal size or out-of-range
MemWriteEn  out  1  memory write enable
MemReadEn  out  1  memory read enable
MemAddress  out  AddressSize  word address = ReqAddr[AddressSize+1:2]
MemWriteData  out  WordSize  memory write data
MemReadData  in  WordSize  memory read data, valid the cycle after MemReadEn

Behaviour:
- Reset: Clock and nReset are as stated above. Reset forces state IDLE and clears all registers. While in reset, ReqReady=1 and RspValid, RspError, RspRData, MemWriteEn, MemReadEn, MemAddress and MemWriteData are all 0.
- Handshake: a request is accepted on a rising edge where ReqValid&&ReqReady. ReqReady=1 only in IDLE. All request fields are captured at accept, so the requester may change them afterwards.
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP. Memory outputs decode from the state register only.
- Error check at accept: RspError=1 if any of the following hold:
  - ReqSize=11
  - half access with ReqAddr[0]=1
  - word access with ReqAddr[1:0]!=0
  - ReqAddr[31:AddressSize+2]!=0
  On error: IDLE->RESP. No memory enable is ever asserted.
- Transitions:
  - Load: IDLE->RD_ISSUE->RD_WAIT->RESP.
  - Word store: IDLE->WR_ISSUE->RESP.
  - Sub-word store: IDLE->RD_ISSUE->RD_WAIT->WR_ISSUE->RESP.
  - RESP->IDLE unconditionally.
- RD_ISSUE: MemReadEn=1, MemAddress=captured word address.
- RD_WAIT: MemReadEn=0. At the end of this cycle, MemReadData is sampled. Only this sample is used; the memory returns 0 when not read.
- WR_ISSUE: MemWriteEn=1, MemAddress valid, MemWriteData = full word or merged word.
- RESP: RspValid=1 for exactly one cycle. RspRData and RspError are held stable during RESP and are 0 otherwise.
- Latency, counted from the accept edge to the cycle RspValid is high:
  - error: 1 cycle
  - word store: 2 cycles
  - load: 3 cycles
  - sub-word store: 4 cycles
- Lanes are little-endian; offset = ReqAddr[1:0].
  - Byte lane = bits [8*off+7 : 8*off].
  - Half lane = bits [16*off[1]+15 : 16*off[1]].
- Load extract: the selected lane is zero-extended, or sign-extended when ReqSigned=1. ReqSigned is ignored for word loads.
- Sub-word merge: only the addressed lane of the read word is replaced with ReqWData[7:0] or ReqWData[15:0]. All other lanes are preserved.
- MemWriteEn and MemReadEn are never asserted in the same cycle.
- Reset mid-operation: the FSM returns to IDLE immediately and the pending response is dropped. After release, no RspValid is produced until a new request is accepted. A reset during WR_ISSUE may leave the memory word unwritten; this is acceptable because the memory also resets.
- Memory output delay: the memory drives its outputs 20 time units after the clock edge. The clock period must exceed 20 time units.

Decomposition:
- Package mem_ctrl_pkg:
  - size_t enum (SZ_BYTE, SZ_HALF, SZ_WORD)
  - state_t enum
  - function is_misaligned(size, addr[1:0])
- Sub-module mem_lane_align: purely combinational. Inputs: word, offset, size, signed flag, store data. Outputs: extracted load value and merged store word. Instantiated once.

Test Plan:
- Word store 0xDEADBEEF to 0x10 -> MemWriteEn=1 one cycle with MemAddress=0x0004; RspValid at cycle 2, RspError=0. Then word load 0x10 -> MemReadEn at cycle 1, RspRData=0xDEADBEEF at cycle 3.
- Byte store 0x11 to 0x13 -> read then write of the same word; RspValid at cycle 4. Word load 0x10 -> 0x11ADBEEF.
- Sub-word loads:
  - signed byte 0x10 -> 0xFFFFFFEF
  - unsigned byte 0x10 -> 0x000000EF
  - signed half 0x10 -> 0xFFFFBEEF
  - signed half 0x12 -> 0x000011AD
- Errors: word load at 0x12, half at 0x11, ReqSize=11, and address 0x00040000 -> each gives RspValid and RspError at cycle 1, RspRData=0, and no MemReadEn/MemWriteEn.
- Assert nReset during RD_WAIT of a load -> all outputs 0 and ReqReady=1 asynchronously; no RspValid after release; the next load completes normally.
- ReqValid held high with a sequence of 4 mixed requests -> each is accepted only in IDLE, each gets exactly one RspValid, and responses come in order with correct data.
